rr_req_sched: RTL and testbench

Per-queue request buffer and dispatcher that sits directly upstream of the `round_robin` index rotator in the PIM controller. It accepts requests tagged with a queue ID and stores them in NQ small per-queue FIFOs. It drives `rr_add` / `rr_rmv` / `rr_nxt` so that only non-empty queues are in rotation, and it dispatches the head request of the queue selected by `rr_idx` through a registered output stage.

---
 rtl/rr_req_sched.sv | 126 ++++++++++++
 tb/tb_rr_req_sched.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_req_sched.sv
// rr_req_sched: per-queue request FIFOs that keep a downstream round_robin rotator
// fed with non-empty queues and dispatch the selected head through a register.
// Optional feature macro: RR_SCHED_BURST_EN (up to BURST pops per queue before rotating).

module rr_req_sched #(
  parameter int NQ     = 16,
  parameter int QDEPTH = 4,
  parameter int WIDTH  = 32,
  parameter int BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [$clog2(NQ)-1:0] in_qid,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [$clog2(NQ)-1:0] out_qid,
  output logic [WIDTH-1:0]      out_data,
  output logic                  rr_add,
  output logic [$clog2(NQ)-1:0] rr_add_val,
  output logic                  rr_rmv,
  output logic                  rr_nxt,
  input  logic [$clog2(NQ)-1:0] rr_idx,
  output logic [NQ-1:0]         q_nempty
);

  localparam int QW = $clog2(NQ);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam int AW = $clog2(NQ + 1);

  if (QDEPTH < 2 || BURST < 1) begin : g_param_chk
    $error("rr_req_sched: QDEPTH must be >= 2 and BURST >= 1");
  end

  logic [WIDTH-1:0] mem [NQ*QDEPTH];
  logic [PW-1:0]    wptr [NQ];
  logic [PW-1:0]    rptr [NQ];
  logic [CW-1:0]    cnt  [NQ];
  logic [CW-1:0]    cnt_nxt [NQ];
  logic [AW-1:0]    active;
  logic             settle;
  logic             push;
  logic             pop;
  logic             drain;
  logic             rotate_ok;

`ifdef RR_SCHED_BURST_EN
  localparam int BCW = (BURST > 1) ? $clog2(BURST) : 1;
  logic [BCW-1:0] burst_cnt;

  assign rotate_ok = (burst_cnt == BCW'(BURST - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_cnt <= '0;
    end else if (rr_nxt || rr_rmv) begin
      burst_cnt <= '0;
    end else if (pop) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end
`else
  assign rotate_ok = 1'b1;
`endif

  always_comb begin
    in_ready = (cnt[in_qid] != CW'(QDEPTH));
    push     = in_valid && in_ready;
    pop      = (!out_valid || out_ready) && (active != '0) && (cnt[rr_idx] != '0) && !settle;
    for (int unsigned q = 0; q < NQ; q++) begin
      cnt_nxt[q]  = cnt[q] + CW'(push && (in_qid == QW'(q))) - CW'(pop && (rr_idx == QW'(q)));
      q_nempty[q] = (cnt[q] != '0);
    end
    // A push landing on the queue being drained keeps it non-empty, so it rotates instead of leaving.
    drain      = pop && (cnt_nxt[rr_idx] == '0);
    rr_add     = push && (cnt[in_qid] == '0);
    rr_add_val = rr_add ? in_qid : '0;
    rr_rmv     = drain;
    rr_nxt     = pop && !drain && rotate_ok;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[{in_qid, wptr[in_qid]}] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned q = 0; q < NQ; q++) begin
        wptr[q] <= '0;
        rptr[q] <= '0;
        cnt[q]  <= '0;
      end
      active    <= '0;
      settle    <= 1'b0;
      out_valid <= 1'b0;
      out_qid   <= '0;
      out_data  <= '0;
    end else begin
      for (int unsigned q = 0; q < NQ; q++) begin
        cnt[q] <= cnt_nxt[q];
      end
      if (push) begin
        wptr[in_qid] <= wptr[in_qid] + 1'b1;
      end
      if (pop) begin
        rptr[rr_idx] <= rptr[rr_idx] + 1'b1;
      end
      active <= active + AW'(rr_add) - AW'(drain);
      // The rotator needs a cycle before rr_idx reflects its first entry.
      settle <= rr_add && (active == '0);
      if (pop) begin
        out_valid <= 1'b1;
        out_qid   <= rr_idx;
        out_data  <= mem[{rr_idx, rptr[rr_idx]}];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_req_sched.sv
// Bench for rr_req_sched: behavioural rotator model on rr_*, output scoreboard,
// one task per scenario. Builds with or without RR_SCHED_BURST_EN.

module tb_rr_req_sched;

  localparam int NQ    = 16;
  localparam int WIDTH = 32;
  localparam int BURST = 4;
  localparam int QW    = 4;
`ifdef RR_SCHED_BURST_EN
  localparam int QD = 8;
`else
  localparam int QD = 4;
`endif

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [QW-1:0]    in_qid;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [QW-1:0]    out_qid;
  logic [WIDTH-1:0] out_data;
  logic             rr_add;
  logic [QW-1:0]    rr_add_val;
  logic             rr_rmv;
  logic             rr_nxt;
  logic [QW-1:0]    rr_idx;
  logic [NQ-1:0]    q_nempty;

  int errors = 0;
  int checks = 0;
  logic [QW+WIDTH-1:0] exp_q [$];
  string seq;

  localparam logic [60:0] RESET_VEC = {1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b0, 1'b0, 16'd0, 1'b1};

  rr_req_sched #(.NQ(NQ), .QDEPTH(QD), .WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_qid(in_qid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_qid(out_qid), .out_data(out_data),
    .rr_add(rr_add), .rr_add_val(rr_add_val), .rr_rmv(rr_rmv), .rr_nxt(rr_nxt),
    .rr_idx(rr_idx), .q_nempty(q_nempty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rotator model: membership mask plus a registered current index.
  logic [NQ-1:0] rot_mask, rot_mask_nxt;
  logic [QW-1:0] rot_idx, rot_idx_nxt, cand;
  logic          found;

  assign rr_idx = rot_idx;

  always_comb begin
    rot_mask_nxt = rot_mask;
    rot_idx_nxt  = rot_idx;
    cand         = '0;
    found        = 1'b0;
    if (rr_add) rot_mask_nxt[rr_add_val] = 1'b1;
    if (rr_rmv) rot_mask_nxt[rot_idx] = 1'b0;
    if (rot_mask == '0 && rr_add) begin
      rot_idx_nxt = rr_add_val;
    end else if (rr_nxt || rr_rmv) begin
      for (int i = 1; i < NQ; i++) begin
        cand = rot_idx + QW'(i);
        if (!found && rot_mask_nxt[cand]) begin
          rot_idx_nxt = cand;
          found       = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rot_mask <= '0;
      rot_idx  <= '0;
    end else begin
      rot_mask <= rot_mask_nxt;
      rot_idx  <= rot_idx_nxt;
    end
  end

  // Scoreboard: every accepted output must match the front of exp_q.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got qid=%0d data=%h, none required", out_qid, out_data);
      end else if ({out_qid, out_data} !== exp_q[0]) begin
        errors++;
        $display("FAIL out_order: got qid=%0d data=%h, required qid=%0d data=%h",
                 out_qid, out_data, exp_q[0][QW+WIDTH-1:WIDTH], exp_q[0][WIDTH-1:0]);
        void'(exp_q.pop_front());
      end else begin
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [QW-1:0] q, input logic [WIDTH-1:0] d);
    in_valid = v;
    in_qid   = q;
    in_data  = d;
  endtask

  task automatic record();
    if (rr_nxt) seq = {seq, "N"};
    if (rr_rmv) seq = {seq, "R"};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 4'd9, 32'h0);
    out_ready = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    checks++;
    if ({out_valid, out_qid, out_data, rr_add, rr_add_val, rr_rmv, rr_nxt, q_nempty, in_ready} !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_values: got %h required %h",
               {out_valid, out_qid, out_data, rr_add, rr_add_val, rr_rmv, rr_nxt, q_nempty, in_ready}, RESET_VEC);
    end
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    cyc();
    drive(1'b1, 4'd3, 32'hA5);
    exp_q.push_back({4'd3, 32'hA5});
    @(negedge clk);
    checks++;
    if ({rr_add, rr_add_val, out_valid} !== {1'b1, 4'd3, 1'b0}) begin
      errors++;
      $display("FAIL single_add: got add=%b val=%0d ov=%b required 1 3 0", rr_add, rr_add_val, out_valid);
    end
    cyc();
    drive(1'b0, 4'd3, 32'h0);
    @(negedge clk);
    checks++;
    if ({out_valid, rr_add, rr_rmv, rr_nxt} !== 4'b0000) begin
      errors++;
      $display("FAIL single_settle: got ov/add/rmv/nxt=%b required 0000", {out_valid, rr_add, rr_rmv, rr_nxt});
    end
    cyc();
    @(negedge clk);
    checks++;
    if ({out_valid, rr_rmv, rr_nxt} !== 3'b010) begin
      errors++;
      $display("FAIL single_pop: got ov/rmv/nxt=%b required 010", {out_valid, rr_rmv, rr_nxt});
    end
    cyc();
    @(negedge clk);
    checks++;
    if ({out_valid, out_qid, out_data, q_nempty} !== {1'b1, 4'd3, 32'hA5, 16'h0}) begin
      errors++;
      $display("FAIL single_out: got ov=%b qid=%0d data=%h nempty=%h required 1 3 a5 0",
               out_valid, out_qid, out_data, q_nempty);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: got out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_order();
    int unsigned qids [6] = '{1, 1, 5, 5, 9, 9};
`ifdef RR_SCHED_BURST_EN
    int unsigned ord [6] = '{0, 1, 2, 3, 4, 5};
    string exp_seq = "RRR";
`else
    int unsigned ord [6] = '{0, 2, 4, 1, 3, 5};
    string exp_seq = "NNNRRR";
`endif
    seq = "";
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) exp_q.push_back({QW'(qids[ord[i]]), WIDTH'(32'h100 + ord[i])});
    for (int i = 0; i < 6; i++) begin
      cyc();
      drive(1'b1, QW'(qids[i]), WIDTH'(32'h100 + i));
      @(negedge clk);
      record();
    end
    cyc();
    drive(1'b0, 4'd0, 32'h0);
    out_ready = 1'b1;
    @(negedge clk);
    record();
    for (int i = 0; i < 11; i++) begin
      cyc();
      @(negedge clk);
      record();
    end
    cyc();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL order_drain: %0d outputs still outstanding, required 0", exp_q.size());
    end
    checks++;
    if (seq != exp_seq) begin
      errors++;
      $display("FAIL order_rr_pulses: got %s required %s", seq, exp_seq);
    end
  endtask

  task automatic test_stall_full();
    out_ready = 1'b0;
    cyc();
    drive(1'b1, 4'd0, 32'h200);
    exp_q.push_back({4'd0, 32'h200});
    cyc();
    drive(1'b0, 4'd0, 32'h0);
    cyc();
    for (int i = 0; i < 5; i++) begin
      cyc();
      @(negedge clk);
      checks++;
      if ({out_valid, out_qid, out_data, rr_add, rr_rmv, rr_nxt} !== {1'b1, 4'd0, 32'h200, 3'b000}) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d got ov=%b qid=%0d data=%h add/rmv/nxt=%b required 1 0 200 000",
                 i, out_valid, out_qid, out_data, {rr_add, rr_rmv, rr_nxt});
      end
    end
    for (int i = 0; i < QD; i++) begin
      cyc();
      drive(1'b1, 4'd2, WIDTH'(32'h300 + i));
      exp_q.push_back({4'd2, WIDTH'(32'h300 + i)});
    end
    cyc();
    drive(1'b1, 4'd2, 32'hDEAD);
    @(negedge clk);
    checks++;
    if ({in_ready, rr_add} !== 2'b00) begin
      errors++;
      $display("FAIL full_q2: got in_ready=%b rr_add=%b required 0 0", in_ready, rr_add);
    end
    in_valid = 1'b0;
    in_qid   = 4'd7;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_other_q7: got in_ready=%b required 1", in_ready);
    end
    cyc();
    out_ready = 1'b1;
    repeat (QD + 4) cyc();
    checks++;
    if (exp_q.size() !== 0 || q_nempty !== 16'h0) begin
      errors++;
      $display("FAIL full_drain: got outstanding=%0d nempty=%h required 0 0", exp_q.size(), q_nempty);
    end
  endtask

  task automatic test_push_on_pop();
`ifdef RR_SCHED_BURST_EN
    logic [2:0] exp_sig = 3'b000;
`else
    logic [2:0] exp_sig = 3'b001;
`endif
    out_ready = 1'b1;
    cyc();
    drive(1'b1, 4'd4, 32'h400);
    exp_q.push_back({4'd4, 32'h400});
    cyc();
    drive(1'b0, 4'd4, 32'h0);
    cyc();
    drive(1'b1, 4'd4, 32'h401);
    exp_q.push_back({4'd4, 32'h401});
    @(negedge clk);
    checks++;
    if ({rr_add, rr_rmv, rr_nxt} !== exp_sig) begin
      errors++;
      $display("FAIL pushpop_rr: got add/rmv/nxt=%b required %b", {rr_add, rr_rmv, rr_nxt}, exp_sig);
    end
    cyc();
    drive(1'b0, 4'd0, 32'h0);
    @(negedge clk);
    checks++;
    if ({q_nempty[4], rr_rmv} !== 2'b11) begin
      errors++;
      $display("FAIL pushpop_cnt: got nempty4=%b rmv=%b required 1 1", q_nempty[4], rr_rmv);
    end
    cyc();
    cyc();
    checks++;
    if (exp_q.size() !== 0 || q_nempty !== 16'h0) begin
      errors++;
      $display("FAIL pushpop_drain: got outstanding=%0d nempty=%h required 0 0", exp_q.size(), q_nempty);
    end
  endtask

  task automatic test_reset_mid();
    logic [QW-1:0] qs [3] = '{4'd6, 4'd11, 4'd6};
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      drive(1'b1, qs[i], WIDTH'(32'h600 + i));
    end
    cyc();
    drive(1'b0, 4'd0, 32'h0);
    @(negedge clk);
    checks++;
    if ({out_valid, q_nempty} !== {1'b1, 16'h0840}) begin
      errors++;
      $display("FAIL midrst_pre: got ov=%b nempty=%h required 1 0840", out_valid, q_nempty);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_qid, out_data, rr_add, rr_add_val, rr_rmv, rr_nxt, q_nempty, in_ready} !== RESET_VEC) begin
      errors++;
      $display("FAIL midrst_values: got %h required %h",
               {out_valid, out_qid, out_data, rr_add, rr_add_val, rr_rmv, rr_nxt, q_nempty, in_ready}, RESET_VEC);
    end
    cyc();
    cyc();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      @(negedge clk);
      checks++;
      if ({out_valid, q_nempty} !== 17'h0) begin
        errors++;
        $display("FAIL midrst_discard: got ov=%b nempty=%h required 0 0", out_valid, q_nempty);
      end
    end
  endtask

`ifdef RR_SCHED_BURST_EN
  task automatic test_burst();
    seq = "";
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back({4'd0, WIDTH'(32'h500 + i)});
    for (int i = 0; i < 4; i++) exp_q.push_back({4'd1, WIDTH'(32'h510 + i)});
    for (int i = 4; i < 6; i++) exp_q.push_back({4'd0, WIDTH'(32'h500 + i)});
    for (int i = 4; i < 6; i++) exp_q.push_back({4'd1, WIDTH'(32'h510 + i)});
    for (int i = 0; i < 12; i++) begin
      cyc();
      drive(1'b1, (i < 6) ? 4'd0 : 4'd1, (i < 6) ? WIDTH'(32'h500 + i) : WIDTH'(32'h510 + i - 6));
    end
    cyc();
    drive(1'b0, 4'd0, 32'h0);
    out_ready = 1'b1;
    @(negedge clk);
    record();
    for (int i = 0; i < 15; i++) begin
      cyc();
      @(negedge clk);
      record();
    end
    cyc();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL burst_drain: %0d outputs still outstanding, required 0", exp_q.size());
    end
    checks++;
    if (seq != "NNRR") begin
      errors++;
      $display("FAIL burst_rr_pulses: got %s required NNRR", seq);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_order();
    test_stall_full();
    test_push_on_pop();
`ifdef RR_SCHED_BURST_EN
    test_burst();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
